uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transceiver transmit path among NREQ byte producers (CSR bridge, debug monitor, DMA, ...).
//  Round-robin grant per byte; drives transceiver tx_data/tx_wr and waits for tx_done before the next byte.
//  Guards against a hung transceiver with a tx_done watchdog. Sits between requesters and uart_transceiver.
// PARAMETERS
//  NREQ      4        number of requesters, 2..8
//  TIMEOUT_W 20       width of watchdog counter
//  TIMEOUT   1000000  sys_clk cycles in WAIT without tx_done before abort (< 2**TIMEOUT_W)
// PORTS
//  sys_clk    in   1       system clock; all logic on rising edge
//  sys_rst_n  in   1       reset, synchronous, active-low
//  req_valid  in   NREQ    requester i has a byte; held stable with data/last until req_ready[i]
//  req_data   in   8*NREQ  byte of requester i at [8*i+7:8*i]
//  req_last   in   NREQ    byte ends a message (used only with UART_ARB_LOCK_EN)
//  req_ready  out  NREQ    one-hot accept; byte consumed when req_valid[i] & req_ready[i]
//  tx_data    out  8       byte to transceiver, registered, stable from ISSUE until next ISSUE
//  tx_wr      out  1       one-cycle transmit strobe to transceiver
//  tx_done    in   1       transceiver pulse: byte fully shifted out
//  grant_id   out  3       index of current/last granted requester
//  busy       out  1       high in ISSUE and WAIT
//  err        out  1       one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (sys_rst_n=0 at edge): state=IDLE, req_ready=0, tx_wr=0, tx_data=8'h00, grant_id=0, busy=0,
//   err=0, rr pointer=NREQ-1 (requester 0 highest priority first), watchdog=0, lock cleared.
//   Reset mid-ISSUE/WAIT aborts silently: no err, byte in flight is not re-sent.
//  States: IDLE -> ISSUE -> WAIT -> IDLE (or ISSUE when locked, see CONFIGURATION).
//  IDLE: if any eligible req_valid, pick first valid index after rr pointer (wrapping NREQ-1 -> 0);
//   latch tx_data<=req_data[g], grant_id<=g, rr pointer<=g, go ISSUE. No valid: stay IDLE.
//  ISSUE (exactly 1 cycle): tx_wr=1, req_ready[g]=1, all other req_ready=0; go WAIT, watchdog<=0.
//  WAIT: watchdog increments each cycle; tx_done=1 -> leave WAIT next edge.
//   watchdog==TIMEOUT-1 and tx_done=0 -> err=1 next cycle, go IDLE, lock cleared.
//   tx_done and timeout in same cycle: tx_done wins, no err.
//   tx_done outside WAIT is ignored.
//  Latency: req_valid rising in IDLE at cycle t -> tx_wr/req_ready at t+1; min byte period = 2 + transceiver time.
//  Requester dropping req_valid before ready: protocol violation, behaviour undefined (bench asserts).
//  req_valid for granted requester is not re-checked in ISSUE (held by protocol).
// CONFIGURATION
//  Macro UART_ARB_LOCK_EN:
//   defined: accepted byte with req_last=0 sets lock on g; while locked only g is eligible and WAIT
//    with tx_done goes directly to ISSUE if req_valid[g]=1 (latching new byte), else IDLE waiting on g only.
//    Byte with req_last=1 clears lock; watchdog abort and reset clear lock. Messages never interleave.
//   undefined: req_last ignored, no lock state; round-robin rearbitrates after every byte.
// STRUCTURE
//  Package uart_arb_pkg: state enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}, grant index width localparam,
//   default TIMEOUT constant.
//  Sub-module uart_rr_pick: combinational round-robin picker (valid vector, pointer, eligible mask ->
//   one-hot grant, index, any). Top holds FSM, data latch, watchdog, lock.
// TESTING
//  1 Reset: drive sys_rst_n=0 with req_valid=4'hF -> req_ready=0, tx_wr=0, tx_data=0, busy=0 throughout.
//  2 Single: req_valid[2]=1, data 8'hA5; tx_done 10 cycles after tx_wr -> one tx_wr with tx_data=A5,
//    req_ready[2] one cycle after valid, grant_id=2, busy drops cycle after tx_done.
//  3 Fairness: all 4 valid continuously, data 8'h10+i -> tx order 10,11,12,13,10,... exactly one tx_wr per tx_done.
//  4 Watchdog: TIMEOUT=16, never pulse tx_done -> err pulse 17 cycles after tx_wr, state IDLE, next requester granted;
//    tx_done coincident with last count -> no err.
//  5 Lock (UART_ARB_LOCK_EN): req0 sends 3 bytes last=0,0,1, req1 valid throughout -> req0's 3 bytes
//    contiguous, then req1; without macro -> bytes alternate 0,1,0,1.
//  6 Reset mid-WAIT: deassert sys_rst_n one cycle during WAIT -> IDLE next cycle, no err, requester 0 wins next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   GRANT_W          : width of the grant index (covers up to 8 requesters)
//   ARB_TIMEOUT_DEF  : default tx_done watchdog limit in sys_clk cycles
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int GRANT_W         = 3;
  localparam int ARB_TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches from the index after i_ptr, wrapping at NREQ-1, for the first
// requester that is both valid and eligible.
//   i_valid  : request vector
//   i_mask   : eligibility mask (all ones when no message lock is held)
//   i_ptr    : index of the last granted requester
//   o_grant  : one-hot grant
//   o_idx    : index of the granted requester
//   o_any    : a grant was found
module uart_rr_pick #(
  parameter int NREQ    = 4,
  parameter int GRANT_W = 3
) (
  input  logic [NREQ-1:0]    i_valid,
  input  logic [NREQ-1:0]    i_mask,
  input  logic [GRANT_W-1:0] i_ptr,
  output logic [NREQ-1:0]    o_grant,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_any
);

  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_shift;
  int              w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = i_valid & i_mask;
    w_shift = '0;
    w_j     = 0;
    // k runs to NREQ so the pointer index itself is the last candidate;
    // this is what lets a locked requester win again.
    for (int k = 1; k <= NREQ; k++) begin
      w_j     = (int'(i_ptr) + k) % NREQ;
      w_shift = w_cand >> w_j;
      if (!o_any && w_shift[0]) begin
        o_any   = 1'b1;
        o_grant = NREQ'(1) << w_j;
        o_idx   = GRANT_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among NREQ byte
// producers. One byte per grant: IDLE picks, ISSUE strobes tx_wr and
// req_ready for one cycle, WAIT holds until tx_done or the watchdog expires.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   defined   : a byte with req_last=0 locks the arbiter onto its requester
//               until a byte with req_last=1 (or abort/reset); messages
//               never interleave.
//   undefined : req_last is ignored, rearbitration after every byte.
//
// Ports
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   req_valid/data/last: requester side, req_ready one-hot accept
//   tx_data, tx_wr     : to transceiver (registered)
//   tx_done            : transceiver byte-complete pulse
//   grant_id           : current/last granted requester
//   busy               : high in ISSUE and WAIT
//   err                : one-cycle pulse on watchdog abort
//
// state     | meaning
// ARB_IDLE  | no byte in flight, arbitrating
// ARB_ISSUE | tx_wr and req_ready asserted for the granted requester
// ARB_WAIT  | waiting for tx_done, watchdog running
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 20,
  parameter int TIMEOUT   = ARB_TIMEOUT_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_done,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 err
);

  arb_state_e           r_state;
  logic [NREQ-1:0]      r_ready;
  logic                 r_tx_wr;
  logic [7:0]           r_tx_data;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic                 r_busy;
  logic                 r_err;
  logic [TIMEOUT_W-1:0] r_wdog;

  logic [NREQ-1:0]      w_elig;
  logic [NREQ-1:0]      w_pick_onehot;
  logic [GRANT_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic [8*NREQ-1:0]    w_data_shift;
  logic [7:0]           w_pick_data;

`ifdef UART_ARB_LOCK_EN
  logic                 r_lock;
  logic [NREQ-1:0]      w_last_shift;
  logic                 w_grant_last;

  // While locked only the owning requester may win.
  assign w_elig       = r_lock ? (NREQ'(1) << r_grant) : '1;
  assign w_last_shift = req_last >> r_grant;
  assign w_grant_last = w_last_shift[0];
`else
  logic                 w_unused_last;

  assign w_elig        = '1;
  assign w_unused_last = ^req_last;
`endif

  uart_rr_pick #(
    .NREQ    (NREQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_mask  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_data_shift = req_data >> {w_pick_idx, 3'b000};
  assign w_pick_data  = w_data_shift[7:0];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ARB_IDLE;
      r_ready   <= '0;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'h00;
      r_grant   <= '0;
      r_rr_ptr  <= GRANT_W'(NREQ - 1);
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_wdog    <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock    <= 1'b0;
`endif
    end else begin
      r_tx_wr <= 1'b0;
      r_ready <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_tx_data <= w_pick_data;
            r_grant   <= w_pick_idx;
            r_rr_ptr  <= w_pick_idx;
            r_ready   <= w_pick_onehot;
            r_tx_wr   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          r_wdog  <= '0;
          r_state <= ARB_WAIT;
`ifdef UART_ARB_LOCK_EN
          r_lock  <= ~w_grant_last;
`endif
        end
        ARB_WAIT: begin
          if (tx_done) begin
            r_state <= ARB_IDLE;
            r_busy  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            // Locked and the owner already has its next byte: skip IDLE.
            if (r_lock && w_pick_any) begin
              r_tx_data <= w_pick_data;
              r_grant   <= w_pick_idx;
              r_rr_ptr  <= w_pick_idx;
              r_ready   <= w_pick_onehot;
              r_tx_wr   <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= ARB_ISSUE;
            end
`endif
          end else if (r_wdog == TIMEOUT_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
            r_lock  <= 1'b0;
`endif
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign tx_data   = r_tx_data;
  assign tx_wr     = r_tx_wr;
  assign grant_id  = r_grant;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transceiver model drive
// the DUT; expected {grant_id, tx_data} pairs are queued as stimulus is
// loaded and compared on every tx_wr.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TW   = 20;
  localparam int TO   = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done = 1'b0;
  logic [2:0]        grant_id;
  logic              busy;
  logic              err;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .TIMEOUT_W (TW),
    .TIMEOUT   (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]  rq [NREQ][$];   // {last, data} per requester
  logic [10:0] exp_q [$];      // {grant_id, tx_data}
  logic [NREQ-1:0] pend_ack = '0;
  int  done_delay = 0;         // 0: transceiver never answers
  int  done_cnt   = 0;
  bit  outstanding = 0;
  int  cyc = 0;
  int  last_wr = 0;
  int  err_cnt = 0;
  int  wr_cnt = 0;
  int  done_total = 0;

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [10:0] e;
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (pend_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    pend_ack = req_valid & req_ready;
    if (tx_wr) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tx_wr: got id=%0d data=%h, required no write", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, tx_data} !== e) begin
          bad++;
          $display("FAIL tx_order: got id=%0d data=%h, required id=%0d data=%h",
                   grant_id, tx_data, e[10:8], e[7:0]);
        end
      end
      total++;
      if (req_ready !== (NREQ'(1) << grant_id)) begin
        bad++;
        $display("FAIL ready_onehot: got %b, required %b", req_ready, NREQ'(1) << grant_id);
      end
      total++;
      if (outstanding) begin
        bad++;
        $display("FAIL tx_wr_overlap: got tx_wr=1 with byte in flight, required 0");
      end
      outstanding = 1;
      last_wr = cyc;
    end
    if (err) begin
      err_cnt++;
      total++;
      if ((cyc - last_wr) !== (TO + 1) || busy !== 1'b0) begin
        bad++;
        $display("FAIL err_timing: got delay=%0d busy=%b, required delay=%0d busy=0",
                 cyc - last_wr, busy, TO + 1);
      end
      outstanding = 0;
    end
    tx_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        tx_done = 1'b1;
        outstanding = 0;
        done_total++;
      end
    end
    if (tx_wr && done_delay > 0) done_cnt = done_delay;
    drive_reqs();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    pend_ack = '0;
    outstanding = 0;
    done_cnt = 0;
    tx_done = 1'b0;
    drive_reqs();
  endtask

  task automatic do_reset();
    clear_model();
    sys_rst_n = 1'b0;
    cycle();
    cycle();
    sys_rst_n = 1'b1;
    cycle();
    err_cnt = 0;
    wr_cnt = 0;
    done_total = 0;
  endtask

  task automatic push(input int id, input logic last, input logic [7:0] d);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    exp_q.push_back({3'(id), d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < budget) begin
      cycle();
      n++;
      idle = (exp_q.size() == 0) && !busy;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) idle = 0;
    end
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL %s_drain: got %0d bytes pending after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) push(i, 1'b1, 8'(8'hE0 + i));
    drive_reqs();
    for (int n = 0; n < 4; n++) begin
      cycle();
      total++;
      if ({req_ready, tx_wr, tx_data, busy, err, grant_id} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got ready=%b wr=%b data=%h busy=%b err=%b gid=%0d, required all 0",
                 req_ready, tx_wr, tx_data, busy, err, grant_id);
      end
    end
    clear_model();
    sys_rst_n = 1'b1;
    cycle();
    cycle();
    total++;
    if (busy !== 1'b0 || tx_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got busy=%b wr=%b, required 0 0", busy, tx_wr);
    end
  endtask

  task automatic test_single();
    do_reset();
    done_delay = 10;
    push(2, 1'b0, 8'hA5);
    expect_tx(2, 8'hA5);
    drive_reqs();
    cycle();
    total++;
    if (tx_wr !== 1'b1 || req_ready !== 4'b0100 || grant_id !== 3'd2 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_issue: got wr=%b ready=%b gid=%0d data=%h busy=%b, required 1 0100 2 a5 1",
               tx_wr, req_ready, grant_id, tx_data, busy);
    end
    for (int n = 0; n < 20 && !tx_done; n++) cycle();
    total++;
    if (tx_done !== 1'b1 || (cyc - last_wr) != 10 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_wait: got done=%b delay=%0d busy=%b, required 1 10 1", tx_done, cyc - last_wr, busy);
    end
    cycle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_drop: got busy=%b, required 0", busy);
    end
    wait_drain("single", 20);
    total++;
    if (wr_cnt != 1) begin
      bad++;
      $display("FAIL single_count: got %0d writes, required 1", wr_cnt);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    done_delay = 3;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        push(i, 1'b0, 8'(8'h10 + i));
        expect_tx(i, 8'(8'h10 + i));
      end
    drive_reqs();
    wait_drain("fair", 200);
    total++;
    if (wr_cnt != 8 || done_total != 8) begin
      bad++;
      $display("FAIL fair_count: got wr=%0d done=%0d, required 8 8", wr_cnt, done_total);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    done_delay = 0;
    push(0, 1'b0, 8'h31);
    push(1, 1'b0, 8'h32);
    expect_tx(0, 8'h31);
    expect_tx(1, 8'h32);
    drive_reqs();
    wait_drain("wdog", 100);
    total++;
    if (err_cnt != 2) begin
      bad++;
      $display("FAIL wdog_err_count: got %0d, required 2", err_cnt);
    end
    do_reset();
    done_delay = TO;
    push(3, 1'b1, 8'h41);
    expect_tx(3, 8'h41);
    drive_reqs();
    wait_drain("wdog_edge", 60);
    total++;
    if (err_cnt != 0 || done_total != 1) begin
      bad++;
      $display("FAIL wdog_coincident: got err=%0d done=%0d, required 0 1", err_cnt, done_total);
    end
  endtask

  task automatic test_lock();
    do_reset();
    done_delay = 4;
    push(0, 1'b0, 8'hA1);
    push(0, 1'b0, 8'hA2);
    push(0, 1'b1, 8'hA3);
    push(1, 1'b1, 8'hB1);
    push(1, 1'b1, 8'hB2);
`ifdef UART_ARB_LOCK_EN
    expect_tx(0, 8'hA1);
    expect_tx(0, 8'hA2);
    expect_tx(0, 8'hA3);
    expect_tx(1, 8'hB1);
    expect_tx(1, 8'hB2);
`else
    expect_tx(0, 8'hA1);
    expect_tx(1, 8'hB1);
    expect_tx(0, 8'hA2);
    expect_tx(1, 8'hB2);
    expect_tx(0, 8'hA3);
`endif
    drive_reqs();
    wait_drain("lock", 300);
    total++;
    if (wr_cnt != 5) begin
      bad++;
      $display("FAIL lock_count: got %0d writes, required 5", wr_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    done_delay = 0;
    push(2, 1'b0, 8'hC1);
    expect_tx(2, 8'hC1);
    drive_reqs();
    cycle();
    cycle();
    cycle();
    cycle();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midwait_busy: got busy=%b, required 1", busy);
    end
    sys_rst_n = 1'b0;
    cycle();
    sys_rst_n = 1'b1;
    outstanding = 0;
    total++;
    if (busy !== 1'b0 || tx_wr !== 1'b0 || req_ready !== '0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midwait_reset: got busy=%b wr=%b ready=%b err=%b, required 0 0 0000 0",
               busy, tx_wr, req_ready, err);
    end
    for (int n = 0; n < 24; n++) cycle();
    total++;
    if (err_cnt != 0 || busy !== 1'b0 || wr_cnt != 1) begin
      bad++;
      $display("FAIL midwait_silent: got err=%0d busy=%b wr=%0d, required 0 0 1", err_cnt, busy, wr_cnt);
    end
    done_delay = 5;
    push(3, 1'b1, 8'hD3);
    push(0, 1'b1, 8'hD0);
    expect_tx(0, 8'hD0);
    expect_tx(3, 8'hD3);
    drive_reqs();
    wait_drain("midwait", 60);
    total++;
    if (err_cnt != 0 || wr_cnt != 3) begin
      bad++;
      $display("FAIL midwait_after: got err=%0d wr=%0d, required 0 3", err_cnt, wr_cnt);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_fairness();
    test_watchdog();
    test_lock();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish before 2ms");
    $fatal(1, "bench timeout");
  end

endmodule
